seq_signed_mult: RTL and testbench

//  Parametrised sequential signed (two's complement) shift-add multiplier with start/busy/done handshake.

---
 rtl/seq_signed_mult.sv | 88 ++++++++
 tb/tb_seq_signed_mult.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/seq_signed_mult.sv
// seq_signed_mult: sequential signed shift-add multiplier with start/busy/done handshake
//   clk, rst (async, active-high); start, multiplier, multiplicand in; busy, done, product, sign out.
//   `define MULT_EARLY_TERM_EN stops iterating once the remaining multiplier magnitude is zero.
module seq_signed_mult #(
  parameter int NBITS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NBITS-1:0]   multiplier,
  input  logic [NBITS-1:0]   multiplicand,
  output logic               busy,
  output logic               done,
  output logic [2*NBITS-1:0] product,
  output logic               sign
);
  localparam int CW = $clog2(NBITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NBITS);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state;
  logic [NBITS-1:0] mag_a, abs_a, abs_b, a_nx;
  logic [2*NBITS-1:0] mag_b, acc, acc_nx, fin_acc;
  logic [CW-1:0] cnt;
  logic neg, fin_go, zero_go;
  always_comb begin
    abs_a = multiplier[NBITS-1] ? -multiplier : multiplier;
    abs_b = multiplicand[NBITS-1] ? -multiplicand : multiplicand;
    acc_nx = acc + (mag_a[0] ? mag_b : '0);
    a_nx = mag_a >> 1;
`ifdef MULT_EARLY_TERM_EN
    fin_go = a_nx == '0;
    fin_acc = acc_nx;
    zero_go = abs_a == '0;
`else
    fin_go = cnt == LAST;
    fin_acc = acc;
    zero_go = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      product <= '0;
      sign <= 1'b0;
      mag_a <= '0;
      mag_b <= '0;
      acc <= '0;
      cnt <= '0;
      neg <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          mag_a <= abs_a;
          mag_b <= {{NBITS{1'b0}}, abs_b};
          acc <= '0;
          cnt <= '0;
          neg <= multiplier[NBITS-1] ^ multiplicand[NBITS-1];
          busy <= 1'b1;
          state <= zero_go ? S_DONE : S_RUN;
          if (zero_go) begin
            done <= 1'b1;
            product <= '0;
            sign <= 1'b0;
          end
        end
        S_RUN: begin
          acc <= acc_nx;
          mag_b <= mag_b << 1;
          mag_a <= a_nx;
          cnt <= cnt + 1'b1;
          if (fin_go) begin
            state <= S_DONE;
            done <= 1'b1;
            product <= neg ? -fin_acc : fin_acc;
            sign <= neg && (fin_acc != '0);
          end
        end
        default: begin
          state <= S_IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_signed_mult.sv
// tb_seq_signed_mult: table, corner-sequence and random checks of seq_signed_mult against integer arithmetic
module tb_seq_signed_mult;
  logic clk = 0, rst = 1, start = 0;
  logic [7:0] multiplier = 0, multiplicand = 0;
  logic busy, done, sign;
  logic [15:0] product;
  int errors = 0, checks = 0;

  seq_signed_mult #(.NBITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .multiplier(multiplier), .multiplicand(multiplicand),
    .busy(busy), .done(done), .product(product), .sign(sign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a, b;
    logic [15:0] p;
    logic s;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [7:0] a);
    int m = a[7] ? -int'($signed(a)) : int'(a);
    int idx = -1;
`ifdef MULT_EARLY_TERM_EN
    for (int i = 0; i < 8; i++) if (m >= (1 << i)) idx = i;
    return idx + 1;
`else
    return (m >= 0) ? 9 : idx;
`endif
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 40) begin @(negedge clk); n++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, output logic [15:0] p,
                    output logic s, output int lat);
    wait_idle();
    multiplier = a; multiplicand = b; start = 1;
    @(posedge clk); #1;
    start = 0;
    chk("busy_after_accept", busy, 1);
    wait_done(lat);
    p = product; s = sign;
    @(posedge clk); #1;
    chk("done_one_cycle", done, 0);
    chk("product_held", product, p);
  endtask

  task automatic check_op(input string nm, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    logic s;
    int lat;
    int r = int'($signed(a)) * int'($signed(b));
    op(a, b, p, s, lat);
    chk({nm, "_product"}, p, r[15:0]);
    chk({nm, "_sign"}, s, r < 0);
    chk({nm, "_latency"}, lat, exp_lat(a));
  endtask

  initial begin
    vec_t tbl[8];
    logic [15:0] p;
    logic s;
    int lat, pulses;
    tbl[0] = '{8'd7, 8'hFD, 16'hFFEB, 1'b1};
    tbl[1] = '{8'h80, 8'h80, 16'h4000, 1'b0};
    tbl[2] = '{8'h80, 8'd127, 16'hC080, 1'b1};
    tbl[3] = '{8'd0, 8'hFB, 16'h0000, 1'b0};
    tbl[4] = '{8'd1, 8'hFF, 16'hFFFF, 1'b1};
    tbl[5] = '{8'd127, 8'd127, 16'h3F01, 1'b0};
    tbl[6] = '{8'hFF, 8'hFF, 16'h0001, 1'b0};
    tbl[7] = '{8'd5, 8'd0, 16'h0000, 1'b0};

    repeat (3) @(negedge clk);
    rst = 0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_product", product, 0);
    chk("reset_sign", sign, 0);

    foreach (tbl[i]) begin
      op(tbl[i].a, tbl[i].b, p, s, lat);
      chk($sformatf("tbl%0d_product", i), p, tbl[i].p);
      chk($sformatf("tbl%0d_sign", i), s, tbl[i].s);
      chk($sformatf("tbl%0d_latency", i), lat, exp_lat(tbl[i].a));
    end

    // start pulse with new operands 3 cycles into RUN must be ignored
    wait_idle();
    multiplier = 8'h80; multiplicand = 8'd5; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    multiplier = 8'd3; multiplicand = 8'd3; start = 1;
    @(negedge clk);
    start = 0;
    pulses = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (done) begin
        pulses++;
        chk("ignored_start_product", product, 16'hFD80);
        chk("ignored_start_sign", sign, 1);
      end
    end
    chk("ignored_start_pulses", pulses, 1);

    // reset in RUN cycle 4 clears outputs immediately
    wait_idle();
    multiplier = 8'd9; multiplicand = 8'd9; start = 1;
    @(posedge clk); #1;
    start = 0;
    repeat (4) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_product", product, 0);
    chk("midrst_sign", sign, 0);
    @(negedge clk);
    rst = 0;
    pulses = 0;
    for (int k = 0; k < 15; k++) begin @(posedge clk); #1; if (done) pulses++; end
    chk("midrst_no_done", pulses, 0);
    check_op("after_rst", 8'd3, 8'hFB);

    for (int k = 0; k < 1000; k++)
      check_op($sformatf("rand%0d", k), 8'($urandom), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
